// File: rtl/vrc_snd_pkg.sv
// rtl/vrc_snd_pkg.sv - shared register map, config types and reload helper for the VRC pulse bank
package vrc_snd_pkg;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_PLO  = 2'd1;
  localparam logic [1:0] REG_PHI  = 2'd2;
  localparam logic [1:0] REG_FREQ = 2'd3;

  typedef struct packed {
    logic        mode;
    logic [2:0]  duty;
    logic [3:0]  vol;
    logic [11:0] period;
    logic        en;
  } pulse_cfg_t;

  typedef struct packed {
    logic halt;
    logic shift4;
    logic shift8;
  } freq_ctl_t;

  // shift8 outranks shift4; result is the value loaded when a counter hits zero
  function automatic logic [11:0] eff_period(input logic [11:0] period, input freq_ctl_t freq);
    if (freq.shift8)      return {8'd0, period[11:8]};
    else if (freq.shift4) return {4'd0, period[11:4]};
    else                  return period;
  endfunction

endpackage

// File: rtl/vrc_pulse_ch.sv
// rtl/vrc_pulse_ch.sv - one pulse channel: registers, period counter, 16-step duty sequencer, level
module vrc_pulse_ch
  import vrc_snd_pkg::*;
#(
  parameter int PERIOD_W = 12,
  parameter int VOL_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             wr,
  input  logic [1:0]       idx,
  input  logic [7:0]       dat,
  input  freq_ctl_t        freq,
  output logic [VOL_W-1:0] level
);

  pulse_cfg_t          cfg;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] reload;
  logic [3:0]          step;
  logic                run;
  logic                clr;

  assign reload = PERIOD_W'(eff_period(cfg.period, freq));
  assign run    = tick && cfg.en && !freq.halt;
  // a disabling write beats a coincident tick
  assign clr    = wr && (idx == REG_PHI) && !dat[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg  <= '0;
      cnt  <= '0;
      step <= 4'hF;
    end else begin
      if (clr) begin
        cnt  <= reload;
        step <= 4'hF;
      end else if (run) begin
        if (cnt == '0) begin
          cnt  <= reload;
          step <= step - 4'd1;
        end else begin
          cnt <= cnt - PERIOD_W'(1);
        end
      end
      if (wr) begin
        case (idx)
          REG_CTRL: {cfg.mode, cfg.duty, cfg.vol} <= dat;
          REG_PLO:  cfg.period[7:0] <= dat;
          REG_PHI: begin
            cfg.en           <= dat[7];
            cfg.period[11:8] <= dat[3:0];
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    level = '0;
    if (cfg.en && (cfg.mode || (step <= {1'b0, cfg.duty})))
      level = VOL_W'(cfg.vol);
  end

endmodule

// File: rtl/vrc_snd_pulse_bank.sv
// rtl/vrc_snd_pulse_bank.sv - VRC expansion audio: pulse bank, global freq control, mixer; VRC_SAW_EN adds the saw channel
module vrc_snd_pulse_bank
  import vrc_snd_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int PERIOD_W = 12,
  parameter int VOL_W    = 4,
  parameter int MIX_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tick,
  input  logic                      reg_we,
  input  logic [3:0]                reg_ch,
  input  logic [1:0]                reg_idx,
  input  logic [7:0]                reg_dat,
  output logic [MIX_W-1:0]          snd_mix,
  output logic [CHANNELS*VOL_W-1:0] ch_out
);

  localparam logic [3:0] GLOBAL_CH = 4'(CHANNELS);
  localparam int         SUM_W     = MIX_W + VOL_W + 6;

  freq_ctl_t  freq;
  logic       glob_wr;
  logic [4:0] saw_level;
  logic [SUM_W-1:0] sum;

  assign glob_wr = reg_we && (reg_ch == GLOBAL_CH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq <= '0;
    end else if (glob_wr && reg_idx == REG_FREQ) begin
      freq.halt   <= reg_dat[0];
      freq.shift4 <= reg_dat[1];
      freq.shift8 <= reg_dat[2];
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    vrc_pulse_ch #(.PERIOD_W(PERIOD_W), .VOL_W(VOL_W)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .wr    (reg_we && (reg_ch == 4'(g))),
      .idx   (reg_idx),
      .dat   (reg_dat),
      .freq  (freq),
      .level (ch_out[g*VOL_W +: VOL_W])
    );
  end

`ifdef VRC_SAW_EN
  logic [5:0]          saw_rate;
  logic [11:0]         saw_period;
  logic                saw_en;
  logic [PERIOD_W-1:0] saw_cnt;
  logic [PERIOD_W-1:0] saw_reload;
  logic                saw_half;
  logic [2:0]          saw_phase;
  logic [7:0]          saw_acc;

  assign saw_reload = PERIOD_W'(eff_period(saw_period, freq));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      saw_rate   <= '0;
      saw_period <= '0;
      saw_en     <= 1'b0;
      saw_cnt    <= '0;
      saw_half   <= 1'b0;
      saw_phase  <= '0;
      saw_acc    <= '0;
    end else begin
      if (!saw_en) begin
        saw_acc   <= '0;
        saw_phase <= '0;
        saw_half  <= 1'b0;
      end else if (tick && !freq.halt) begin
        if (saw_cnt == '0) begin
          saw_cnt  <= saw_reload;
          saw_half <= ~saw_half;
          // accumulate on every second reload, restarting after six steps
          if (saw_half) begin
            if (saw_phase == 3'd6) begin
              saw_acc   <= '0;
              saw_phase <= '0;
            end else begin
              saw_acc   <= saw_acc + {2'b00, saw_rate};
              saw_phase <= saw_phase + 3'd1;
            end
          end
        end else begin
          saw_cnt <= saw_cnt - PERIOD_W'(1);
        end
      end
      if (glob_wr) begin
        case (reg_idx)
          REG_CTRL: saw_rate <= reg_dat[5:0];
          REG_PLO:  saw_period[7:0] <= reg_dat;
          REG_PHI: begin
            saw_en           <= reg_dat[7];
            saw_period[11:8] <= reg_dat[3:0];
            if (!reg_dat[7]) begin
              saw_cnt   <= saw_reload;
              saw_acc   <= '0;
              saw_phase <= '0;
              saw_half  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign saw_level = saw_acc[7:3];
`else
  assign saw_level = '0;
`endif

  always_comb begin
    sum = SUM_W'(saw_level);
    for (int i = 0; i < CHANNELS; i++)
      sum = sum + SUM_W'(ch_out[i*VOL_W +: VOL_W]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      snd_mix <= '0;
    else if (sum > SUM_W'({MIX_W{1'b1}}))
      snd_mix <= '1;
    else
      snd_mix <= sum[MIX_W-1:0];
  end

endmodule

// File: tb/tb_vrc_snd_pulse_bank.sv
// tb/tb_vrc_snd_pulse_bank.sv - scoreboard bench: cycle model of a 3-channel bank plus a small saturating instance
module tb_vrc_snd_pulse_bank;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic        reg_we;
  logic        reg_we2;
  logic [3:0]  reg_ch;
  logic [1:0]  reg_idx;
  logic [7:0]  reg_dat;
  logic [7:0]  snd_mix;
  logic [11:0] ch_out;
  logic [3:0]  snd_mix2;
  logic [7:0]  ch_out2;

  int n_chk  = 0;
  int n_fail = 0;

  vrc_snd_pulse_bank #(.CHANNELS(3), .PERIOD_W(12), .VOL_W(4), .MIX_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .reg_we(reg_we), .reg_ch(reg_ch),
    .reg_idx(reg_idx), .reg_dat(reg_dat), .snd_mix(snd_mix), .ch_out(ch_out)
  );

  vrc_snd_pulse_bank #(.CHANNELS(2), .PERIOD_W(12), .VOL_W(4), .MIX_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .reg_we(reg_we2), .reg_ch(reg_ch),
    .reg_idx(reg_idx), .reg_dat(reg_dat), .snd_mix(snd_mix2), .ch_out(ch_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  mix;
    logic [11:0] chout;
  } exp_t;
  exp_t sb[$];

  int m_mode[3], m_duty[3], m_vol[3], m_per[3], m_en[3], m_cnt[3], m_step[3];
  int m_halt, m_s4, m_s8;
  int s_rate, s_per, s_en, s_cnt, s_half, s_phase, s_acc;

  function automatic int eff(input int p);
    if (m_s8) return p >> 8;
    if (m_s4) return p >> 4;
    return p;
  endfunction

  function automatic int lvl(input int c);
    if (m_en[c] == 0) return 0;
    if (m_mode[c] != 0 || m_step[c] <= m_duty[c]) return m_vol[c];
    return 0;
  endfunction

  function automatic int mix_now();
    int s;
    s = lvl(0) + lvl(1) + lvl(2);
`ifdef VRC_SAW_EN
    s = s + (s_acc >> 3);
`endif
    return (s > 255) ? 255 : s;
  endfunction

  function automatic logic [11:0] chout_now();
    return {4'(lvl(2)), 4'(lvl(1)), 4'(lvl(0))};
  endfunction

  // reference model: snapshot the mix from pre-edge state, then apply tick and write
  always @(posedge clk or negedge rst_n) begin : model
    exp_t e;
    int eo[3];
    int se, c, ix, d;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_mode[k] = 0; m_duty[k] = 0; m_vol[k] = 0; m_per[k] = 0;
        m_en[k] = 0; m_cnt[k] = 0; m_step[k] = 15;
      end
      m_halt = 0; m_s4 = 0; m_s8 = 0;
      s_rate = 0; s_per = 0; s_en = 0; s_cnt = 0; s_half = 0; s_phase = 0; s_acc = 0;
      sb.delete();
      e.mix = 8'd0;
      e.chout = 12'd0;
      sb.push_back(e);
    end else begin
      e.mix = 8'(mix_now());
      for (int k = 0; k < 3; k++) eo[k] = eff(m_per[k]);
      se = eff(s_per);
      for (int k = 0; k < 3; k++) begin
        if (tick && m_en[k] != 0 && m_halt == 0) begin
          if (m_cnt[k] == 0) begin
            m_cnt[k] = eo[k];
            m_step[k] = (m_step[k] + 15) % 16;
          end else begin
            m_cnt[k] = m_cnt[k] - 1;
          end
        end
      end
`ifdef VRC_SAW_EN
      if (s_en == 0) begin
        s_acc = 0; s_phase = 0; s_half = 0;
      end else if (tick && m_halt == 0) begin
        if (s_cnt == 0) begin
          s_cnt = se;
          if (s_half != 0) begin
            if (s_phase == 6) begin
              s_acc = 0; s_phase = 0;
            end else begin
              s_acc = (s_acc + s_rate) % 256; s_phase = s_phase + 1;
            end
          end
          s_half = 1 - s_half;
        end else begin
          s_cnt = s_cnt - 1;
        end
      end
`endif
      if (reg_we) begin
        c = int'(reg_ch); ix = int'(reg_idx); d = int'(reg_dat);
        if (c < 3) begin
          case (ix)
            0: begin m_mode[c] = d >> 7; m_duty[c] = (d >> 4) & 7; m_vol[c] = d & 15; end
            1: m_per[c] = (m_per[c] & 'hF00) | d;
            2: begin
              m_per[c] = (m_per[c] & 'hFF) | ((d & 15) << 8);
              m_en[c] = d >> 7;
              if (m_en[c] == 0) begin m_cnt[c] = eo[c]; m_step[c] = 15; end
            end
            default: ;
          endcase
        end else if (c == 3) begin
          if (ix == 3) begin
            m_halt = d & 1; m_s4 = (d >> 1) & 1; m_s8 = (d >> 2) & 1;
          end
`ifdef VRC_SAW_EN
          else if (ix == 0) s_rate = d & 63;
          else if (ix == 1) s_per = (s_per & 'hF00) | d;
          else begin
            s_per = (s_per & 'hFF) | ((d & 15) << 8);
            s_en = d >> 7;
            if (s_en == 0) begin s_cnt = se; s_acc = 0; s_phase = 0; s_half = 0; end
          end
`endif
        end
      end
      e.chout = chout_now();
      sb.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_mix", 32'(snd_mix), 32'(e.mix));
      check("sb_ch_out", 32'(ch_out), 32'(e.chout));
    end
  end

  task automatic cyc(input logic t, input logic we, input logic [3:0] ch,
                     input logic [1:0] idx, input logic [7:0] d, input logic we2);
    tick = t; reg_we = we; reg_ch = ch; reg_idx = idx; reg_dat = d; reg_we2 = we2;
    @(posedge clk);
    #1;
    tick = 1'b0; reg_we = 1'b0; reg_we2 = 1'b0;
  endtask

  task automatic wr(input logic [3:0] ch, input logic [1:0] idx, input logic [7:0] d);
    cyc(1'b0, 1'b1, ch, idx, d, 1'b0);
  endtask

  task automatic wr2(input logic [3:0] ch, input logic [1:0] idx, input logic [7:0] d);
    cyc(1'b0, 1'b0, ch, idx, d, 1'b1);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 4'd0, 2'd0, 8'd0, 1'b0);
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 4'd0, 2'd0, 8'd0, 1'b0);
      idle();
    end
  endtask

  function automatic logic [3:0] lv(input int c);
    return ch_out[c*4 +: 4];
  endfunction

  initial begin : stim
    int hi;
    logic [7:0] saw_tab [8];
    saw_tab = '{8'd0, 8'd5, 8'd10, 8'd15, 8'd21, 8'd26, 8'd31, 8'd0};
    rst_n = 1'b0; tick = 1'b0; reg_we = 1'b0; reg_we2 = 1'b0;
    reg_ch = '0; reg_idx = '0; reg_dat = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_mix", 32'(snd_mix), 32'd0);
    check("rst_ch_out", 32'(ch_out), 32'd0);

    do_ticks(1000);
    check("idle_mix", 32'(snd_mix), 32'd0);

    wr(4'd0, 2'd0, 8'h7F);
    wr(4'd0, 2'd1, 8'h03);
    wr(4'd0, 2'd2, 8'h80);
    do_ticks(1);
    check("pulse_t1", 32'(lv(0)), 32'd0);
    do_ticks(27);
    check("pulse_t28", 32'(lv(0)), 32'd0);
    do_ticks(1);
    check("pulse_t29", 32'(lv(0)), 32'd15);
    hi = 0;
    for (int i = 0; i < 64; i++) begin
      do_ticks(1);
      if (lv(0) == 4'd15) hi++;
    end
    check("duty7_high_ticks", 32'(hi), 32'd32);

    wr(4'd0, 2'd0, 8'h89);
    idle();
    check("digital_mix", 32'(snd_mix), 32'd9);
    do_ticks(20);
    check("digital_hold", 32'(snd_mix), 32'd9);
    wr(4'd0, 2'd2, 8'h00);

    wr(4'd3, 2'd3, 8'h04);
    wr(4'd1, 2'd0, 8'h0F);
    wr(4'd1, 2'd1, 8'hFF);
    wr(4'd1, 2'd2, 8'h83);
    do_ticks(1);
    hi = 0;
    for (int i = 0; i < 64; i++) begin
      do_ticks(1);
      if (lv(1) == 4'd15) hi++;
    end
    check("shift8_step0_ticks", 32'(hi), 32'd4);
    wr(4'd3, 2'd3, 8'h06);
    hi = 0;
    for (int i = 0; i < 64; i++) begin
      do_ticks(1);
      if (lv(1) == 4'd15) hi++;
    end
    check("shift8_4_step0_ticks", 32'(hi), 32'd4);

    cyc(1'b1, 1'b1, 4'd1, 2'd2, 8'h03, 1'b0);
    check("disable_level", 32'(lv(1)), 32'd0);
    wr(4'd1, 2'd0, 8'h7F);
    wr(4'd1, 2'd2, 8'h83);
    do_ticks(31);
    check("reenable_t31", 32'(lv(1)), 32'd0);
    do_ticks(1);
    check("reenable_t32", 32'(lv(1)), 32'd15);

    wr(4'd3, 2'd3, 8'h05);
    check("halt_level", 32'(ch_out), 32'h0F0);
    do_ticks(50);
    check("halt_hold", 32'(ch_out), 32'h0F0);
    wr(4'd3, 2'd3, 8'h04);

    wr(4'd5, 2'd0, 8'hFF);
    wr(4'd0, 2'd3, 8'hFF);
    wr(4'd3, 2'd0, 8'hFF);
    do_ticks(10);

`ifdef VRC_SAW_EN
    wr(4'd1, 2'd2, 8'h00);
    wr(4'd3, 2'd0, 8'd42);
    wr(4'd3, 2'd1, 8'h00);
    wr(4'd3, 2'd2, 8'h80);
    idle();
    check("saw_start", 32'(snd_mix), 32'd0);
    for (int i = 1; i < 8; i++) begin
      do_ticks(2);
      check("saw_level", 32'(snd_mix), 32'(saw_tab[i]));
    end
    for (int c = 0; c < 3; c++) begin
      wr(4'(c), 2'd0, 8'h8F);
      wr(4'(c), 2'd2, 8'h80);
    end
    do_ticks(2);
    check("saw_plus_pulses", 32'(snd_mix), 32'd50);
`endif

    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_mix", 32'(snd_mix), 32'd0);
    check("async_rst_ch_out", 32'(ch_out), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    wr2(4'd0, 2'd0, 8'h87);
    wr2(4'd0, 2'd2, 8'h80);
    wr2(4'd1, 2'd0, 8'h88);
    wr2(4'd1, 2'd2, 8'h80);
    idle();
    check("mix4_exact_max", 32'(snd_mix2), 32'd15);
    wr2(4'd1, 2'd0, 8'h89);
    idle();
    check("mix4_saturate", 32'(snd_mix2), 32'd15);
    wr2(4'd1, 2'd0, 8'h83);
    idle();
    check("mix4_below", 32'(snd_mix2), 32'd10);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
